// File: rtl/sqrt_sequencer.sv
// Sequencer that feeds IEEE-754 single-precision operands to an external Newton sqrt stage.
// Special operands are answered directly. Normal operands are seeded, stepped N_ITER times, then captured.
module sqrt_sequencer #(
    parameter int N_ITER      = 6,
    parameter int STEP_CYCLES = 32
) (
    input  logic        int_clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [31:0] sq_a,
    output logic        sq_start,
    output logic        sq_step,
    input  logic [31:0] sq_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_flag,
    output logic        busy
);

    // state   | meaning
    // IDLE    | waiting for an operand, in_ready high
    // LOAD    | sq_start strobe, seeds the sqrt stage
    // ITER    | step timer running, sq_step on each terminal count
    // CAPTURE | register sq_result as the final estimate
    // DONE    | result held until out_ready
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_ITER    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [7:0]  STEP_RELOAD = 8'(STEP_CYCLES - 1);
    localparam logic [3:0]  ITER_LAST   = 4'(N_ITER - 1);
    localparam logic [31:0] QNAN        = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF     = 32'h7F80_0000;

    localparam logic [1:0] FLAG_NORMAL = 2'b00;
    localparam logic [1:0] FLAG_ZERO   = 2'b01;
    localparam logic [1:0] FLAG_NAN    = 2'b10;
    localparam logic [1:0] FLAG_INF    = 2'b11;

    logic [2:0]  state_q,    state_d;
    logic [7:0]  step_cnt_q, step_cnt_d;
    logic [3:0]  iter_cnt_q, iter_cnt_d;
    logic [31:0] sq_a_q,     sq_a_d;
    logic [31:0] out_data_q, out_data_d;
    logic [1:0]  out_flag_q, out_flag_d;

    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_mant;
    logic        is_special;
    logic [31:0] spec_data;
    logic [1:0]  spec_flag;
    logic        accept;

    assign in_sign = in_data[31];
    assign in_exp  = in_data[30:23];
    assign in_mant = in_data[22:0];

    // Denormals are flushed to a signed zero, so a negative denormal is zero rather than NaN.
    always_comb begin
        is_special = 1'b1;
        spec_data  = QNAN;
        spec_flag  = FLAG_NAN;
        if (in_exp == 8'h00) begin
            spec_data = {in_sign, 31'b0};
            spec_flag = FLAG_ZERO;
        end else if (in_sign) begin
            spec_data = QNAN;
            spec_flag = FLAG_NAN;
        end else if (in_exp == 8'hFF && in_mant != 23'd0) begin
            spec_data = QNAN;
            spec_flag = FLAG_NAN;
        end else if (in_exp == 8'hFF) begin
            spec_data = POS_INF;
            spec_flag = FLAG_INF;
        end else begin
            is_special = 1'b0;
        end
    end

    assign accept = in_valid && (state_q == S_IDLE);

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        iter_cnt_d = iter_cnt_q;
        sq_a_d     = sq_a_q;
        out_data_d = out_data_q;
        out_flag_d = out_flag_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sq_a_d = in_data;
                    if (is_special) begin
                        out_data_d = spec_data;
                        out_flag_d = spec_flag;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                step_cnt_d = STEP_RELOAD;
                iter_cnt_d = 4'd0;
                state_d    = S_ITER;
            end
            S_ITER: begin
                if (step_cnt_q == 8'd0) begin
                    step_cnt_d = STEP_RELOAD;
                    if (iter_cnt_q == ITER_LAST) begin
                        state_d = S_CAPTURE;
                    end else begin
                        iter_cnt_d = iter_cnt_q + 4'd1;
                    end
                end else begin
                    step_cnt_d = step_cnt_q - 8'd1;
                end
            end
            S_CAPTURE: begin
                out_data_d = sq_result;
                out_flag_d = FLAG_NORMAL;
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge int_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            step_cnt_q <= 8'd0;
            iter_cnt_q <= 4'd0;
            sq_a_q     <= 32'd0;
            out_data_q <= 32'd0;
            out_flag_q <= FLAG_NORMAL;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            iter_cnt_q <= iter_cnt_d;
            sq_a_q     <= sq_a_d;
            out_data_q <= out_data_d;
            out_flag_q <= out_flag_d;
        end
    end

    // Strobes decode from registered state only, so they cannot overlap or leak outside LOAD/ITER.
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign sq_start  = (state_q == S_LOAD);
    assign sq_step   = (state_q == S_ITER) && (step_cnt_q == 8'd0);
    assign out_valid = (state_q == S_DONE);
    assign sq_a      = sq_a_q;
    assign out_data  = out_data_q;
    assign out_flag  = out_flag_q;

endmodule

// File: tb/tb_sqrt_sequencer.sv
// Directed bench for sqrt_sequencer: normal, special, backpressure and mid-operation reset scenarios.
// The bench drives sq_result as the downstream sqrt stage's final estimate.
module tb_sqrt_sequencer;

    logic        int_clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] sq_a;
    logic        sq_start;
    logic        sq_step;
    logic [31:0] sq_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_flag;
    logic        busy;

    int errors = 0;
    int checks = 0;

    sqrt_sequencer #(.N_ITER(6), .STEP_CYCLES(32)) dut (
        .int_clk   (int_clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sq_a      (sq_a),
        .sq_start  (sq_start),
        .sq_step   (sq_step),
        .sq_result (sq_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flag  (out_flag),
        .busy      (busy)
    );

    initial int_clk = 1'b0;
    always #5 int_clk = ~int_clk;

    task automatic check_reset_outputs(input string name);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'd0 || out_flag !== 2'b00 ||
            sq_a !== 32'd0 || sq_start !== 1'b0 || sq_step !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: got in_ready=%b out_valid=%b out_data=%h out_flag=%b sq_a=%h sq_start=%b sq_step=%b busy=%b, want 1 0 00000000 00 00000000 0 0 0",
                     name, in_ready, out_valid, out_data, out_flag, sq_a, sq_start, sq_step, busy);
        end
    endtask

    task automatic handshake(input string name);
        @(negedge int_clk);
        out_ready = 1'b1;
        @(negedge int_clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_handshake: got in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                     name, in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset;
        #3;
        check_reset_outputs("reset_hold");
        @(negedge int_clk);
        rst_n = 1'b1;
        @(negedge int_clk);
        check_reset_outputs("reset_release");
    endtask

    task automatic test_out_ready_idle;
        int bad;
        bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge int_clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        out_ready = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL out_ready_idle: got %0d disturbed cycles, want 0", bad);
        end
    endtask

    task automatic run_normal(input logic [31:0] d, input logic [31:0] res,
                              input logic [31:0] exp_data, input int exp_valid_cyc,
                              input string name);
        int steps, starts, bad_step, bad_start, both, first_valid, bad_cyc1;
        steps = 0; starts = 0; bad_step = 0; bad_start = 0; both = 0; first_valid = 0; bad_cyc1 = 0;
        @(negedge int_clk);
        sq_result = res;
        in_data   = d;
        in_valid  = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: got in_ready=%b, want 1", name, in_ready);
        end
        for (int cyc = 1; cyc <= 300 && first_valid == 0; cyc++) begin
            @(negedge int_clk);
            if (cyc == 1) begin
                in_valid = 1'b0;
                if (busy !== 1'b1 || sq_a !== d || out_valid !== 1'b0) bad_cyc1++;
            end
            if (sq_start === 1'b1) begin
                starts++;
                if (cyc != 1) bad_start++;
            end
            if (sq_step === 1'b1) begin
                steps++;
                if (cyc != 1 + steps * 32) bad_step++;
            end
            if (sq_start === 1'b1 && sq_step === 1'b1) both++;
            if (out_valid === 1'b1) first_valid = cyc;
        end
        checks++;
        if (bad_cyc1 != 0) begin
            errors++;
            $display("FAIL %s_cycle1: got busy=%b sq_a=%h out_valid=%b, want 1 %h 0", name, busy, sq_a, out_valid, d);
        end
        checks++;
        if (starts != 1 || bad_start != 0) begin
            errors++;
            $display("FAIL %s_start: got %0d sq_start cycles (%0d misplaced), want 1 at cycle 1", name, starts, bad_start);
        end
        checks++;
        if (steps != 6 || bad_step != 0) begin
            errors++;
            $display("FAIL %s_steps: got %0d pulses (%0d misplaced), want 6 at 33+32k", name, steps, bad_step);
        end
        checks++;
        if (both != 0) begin
            errors++;
            $display("FAIL %s_overlap: got %0d cycles with sq_start and sq_step, want 0", name, both);
        end
        checks++;
        if (first_valid != exp_valid_cyc) begin
            errors++;
            $display("FAIL %s_valid_cycle: got %0d, want %0d", name, first_valid, exp_valid_cyc);
        end
        checks++;
        if (out_data !== exp_data || out_flag !== 2'b00) begin
            errors++;
            $display("FAIL %s_result: got %h flag %b, want %h flag 00", name, out_data, out_flag, exp_data);
        end
        handshake(name);
    endtask

    task automatic run_special(input logic [31:0] d, input logic [31:0] exp_data,
                               input logic [1:0] exp_flag, input string name);
        @(negedge int_clk);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge int_clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_data || out_flag !== exp_flag) begin
            errors++;
            $display("FAIL %s: got valid=%b data=%h flag=%b, want 1 %h %b",
                     name, out_valid, out_data, out_flag, exp_data, exp_flag);
        end
        checks++;
        if (sq_start !== 1'b0 || sq_step !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_strobes: got sq_start=%b sq_step=%b busy=%b, want 0 0 1", name, sq_start, sq_step, busy);
        end
        handshake(name);
    endtask

    task automatic test_backpressure;
        int bad;
        bad = 0;
        @(negedge int_clk);
        in_data  = 32'h8000_0000;
        in_valid = 1'b1;
        @(negedge int_clk);
        in_valid = 1'b0;
        for (int i = 2; i <= 11; i++) begin
            @(negedge int_clk);
            if (i == 3) begin
                in_data  = 32'h7F80_0000;
                in_valid = 1'b1;
            end
            if (out_valid !== 1'b1 || out_data !== 32'h8000_0000 || out_flag !== 2'b01 ||
                in_ready !== 1'b0 || sq_a !== 32'h8000_0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d unstable cycles, want 0 (data=%h flag=%b in_ready=%b sq_a=%h)",
                     bad, out_data, out_flag, in_ready, sq_a);
        end
        out_ready = 1'b1;
        @(negedge int_clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sq_a !== 32'h8000_0000) begin
            errors++;
            $display("FAIL stall_release: got in_ready=%b out_valid=%b sq_a=%h, want 1 0 80000000", in_ready, out_valid, sq_a);
        end
        @(negedge int_clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h7F80_0000 || out_flag !== 2'b11 || sq_a !== 32'h7F80_0000) begin
            errors++;
            $display("FAIL stall_next: got valid=%b data=%h flag=%b sq_a=%h, want 1 7f800000 11 7f800000",
                     out_valid, out_data, out_flag, sq_a);
        end
        handshake("stall_next");
    endtask

    task automatic test_reset_mid;
        int late;
        late = 0;
        @(negedge int_clk);
        sq_result = 32'h4000_0000;
        in_data   = 32'h4080_0000;
        in_valid  = 1'b1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge int_clk);
            if (cyc == 1) in_valid = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_async");
        @(negedge int_clk);
        @(negedge int_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 250; i++) begin
            @(negedge int_clk);
            if (sq_step !== 1'b0 || out_valid !== 1'b0 || sq_start !== 1'b0) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d cycles with strobes or out_valid, want 0", late);
        end
        run_normal(32'h4180_0000, 32'h4080_0000, 32'h4080_0000, 195, "after_reset");
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        sq_result = 32'd0;
        test_reset;
        test_out_ready_idle;
        run_normal(32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 195, "sqrt4");
        run_special(32'hC080_0000, 32'h7FC0_0000, 2'b10, "neg4");
        run_special(32'h8000_0000, 32'h8000_0000, 2'b01, "negzero");
        run_special(32'h7F80_0000, 32'h7F80_0000, 2'b11, "posinf");
        run_special(32'h7FC0_0001, 32'h7FC0_0000, 2'b10, "nan");
        run_special(32'h0000_0001, 32'h0000_0000, 2'b01, "denorm");
        test_backpressure;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sqrt_sequencer.md
SQRT_SEQUENCER -- requirements
Module: sqrt_sequencer

Interface
- REQ-001: The block SHALL expose the parameter N_ITER, default 6, which sets the number of Newton iterations per operand (legal range 1..15).
- REQ-002: The block SHALL expose the parameter STEP_CYCLES, default 32, which sets the int_clk cycles per iteration and allows divider settling (legal range 2..255).
- REQ-003: int_clk  input  1  the single clock; all state SHALL update on its rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous and active-low.
- REQ-005: in_valid  input  1  operand valid.
- REQ-006: in_ready  output  1  the block accepts an operand.
- REQ-007: in_data  input  32  IEEE-754 single-precision operand.
- REQ-008: sq_a  output  32  operand driven to the downstream Newton sqrt stage.
- REQ-009: sq_start  output  1  seed-load strobe to the sqrt stage.
- REQ-010: sq_step  output  1  single-cycle iteration-advance pulse to the sqrt stage.
- REQ-011: sq_result  input  32  current estimate returned by the sqrt stage.
- REQ-012: out_valid  output  1  result valid.
- REQ-013: out_ready  input  1  consumer accepts the result.
- REQ-014: out_data  output  32  square-root result.
- REQ-015: out_flag  output  2  result class: 00 normal, 01 zero, 10 NaN, 11 infinity.
- REQ-016: busy  output  1  high whenever the state is not IDLE.

Function
- REQ-017: The state machine SHALL have the states IDLE, LOAD, ITER, CAPTURE and DONE.
- REQ-018: in_ready SHALL be 1 only in IDLE; in_valid SHALL be ignored in all other states.
- REQ-019: Accept SHALL occur on the edge where in_valid and in_ready are both 1; in_data SHALL be registered into sq_a and held until the next accept.
- REQ-020: Classification at accept SHALL be: exp==0 gives out_data {sign,31'b0}, flag 01; sign==1 with nonzero exp gives 7FC00000, flag 10; exp==FF with mantissa!=0 gives 7FC00000, flag 10; +inf gives 7F800000, flag 11.
- REQ-021: A special operand SHALL go IDLE->DONE directly, with out_valid high in cycle 1 (cycle n = n cycles after the accept edge) and no sq_start or sq_step pulses.
- REQ-022: A normal operand SHALL go to LOAD; sq_start SHALL be high in cycle 1 only.
- REQ-023: In ITER, an 8-bit step counter SHALL pulse sq_step in cycles 1+k*STEP_CYCLES for k=1..N_ITER; a 4-bit iteration counter SHALL count the pulses.
- REQ-024: After the N_ITER-th pulse, the state SHALL go to CAPTURE for cycle 2+N_ITER*STEP_CYCLES, registering sq_result into out_data with flag 00.
- REQ-025: out_valid SHALL go high from cycle 3+N_ITER*STEP_CYCLES; with the defaults, pulses occur at 33, 65, ..., 193, capture at 194 and out_valid at 195.
- REQ-026: In DONE, out_valid, out_data and out_flag SHALL stay stable until out_ready is 1; on handshake the state SHALL return to IDLE, with in_ready 1 in the following cycle (no same-cycle accept).
- REQ-027: out_ready asserted while out_valid is 0 SHALL have no effect.
- REQ-028: sq_start and sq_step SHALL never be high simultaneously or outside LOAD/ITER.

Reset
- REQ-029: While rst_n is 0, the state SHALL be IDLE; in_ready 1; out_valid 0; out_data 0; out_flag 00; sq_a 0; sq_start 0; sq_step 0; busy 0.
- REQ-030: rst_n assertion mid-operation SHALL abort the operation immediately (asynchronously); no sq_step pulse or out_valid SHALL follow until a new accept.
- REQ-031: The first accept after rst_n deassertion SHALL behave identically to the first accept after power-up.

Verification
- REQ-032: in_data 40800000 (4.0), with the sqrt-stage model returning 40000000 -> exactly 6 sq_step pulses spaced 32 cycles, and out_data 40000000 with flag 00 and out_valid at cycle 195.
- REQ-033: in_data C0800000 (-4.0) -> out_data 7FC00000 with flag 10 at cycle 1, and no sq_start or sq_step pulses.
- REQ-034: in_data 80000000 -> out_data 80000000 with flag 01; in_data 7F800000 -> out_data 7F800000 with flag 11; in_data 7FC00001 -> out_data 7FC00000 with flag 10.
- REQ-035: out_ready held 0 for 10 cycles after out_valid, with in_valid pulsed -> out_data stable, in_ready 0 and the new operand not accepted; accepted only after the handshake.
- REQ-036: rst_n low at cycle 100 of a normal operation -> all outputs take their reset values at once and no further sq_step occurs; the next operand 41800000 completes with out_valid at cycle 195.
